// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator. A clock divider produces a
// one-clk pixel enable (p_tick); horizontal/vertical counters advance on it.
// Sync and blank are decoded from the counters and then delayed by PIPE pixel
// ticks so they line up with a downstream pixel pipeline. Start/stop requests
// on en take effect only at a frame boundary, so a frame is never cut short.
//
// Ports
//   clk_100MHz   system clock, all logic on the rising edge
//   reset        asynchronous active-low reset
//   en           run request
//   p_tick       pixel enable, one clk wide
//   x, y         horizontal / vertical counters
//   video_on     visible-area flag (delayed PIPE pixel ticks)
//   hsync/vsync  sync outputs with HS_POL/VS_POL active level (delayed)
//   line_tick    pulse on the last pixel of every line
//   refresh_tick pulse on the last pixel of every frame
//   frame_cnt    completed frames, wraps
//   running      high while the generator is producing frames
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10,
    parameter int PIPE     = 2,
    parameter int FRAME_W  = 8
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               en,
    output logic               p_tick,
    output logic [CW-1:0]      x,
    output logic [CW-1:0]      y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_tick,
    output logic               refresh_tick,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
    localparam logic [CW-1:0]      X_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]      Y_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
    localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

    // Decode bounds kept 32 bits wide so an end bound equal to the total
    // never overflows the CW-bit counter width.
    localparam logic [31:0] H_VIS    = 32'(H_ACTIVE);
    localparam logic [31:0] V_VIS    = 32'(V_ACTIVE);
    localparam logic [31:0] HS_BEGIN = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_BEGIN = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [CW-1:0]        x_q, x_d;
    logic [CW-1:0]        y_q, y_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 running_q, running_d;

    logic                 p_tick_s;
    logic                 eol_s;
    logic                 eof_s;
    logic [31:0]          x_ext_s;
    logic [31:0]          y_ext_s;
    logic [2:0]           raw_s;   // {vs_act, hs_act, visible}
    logic [2:0]           dly_s;
    logic                 active_s;

    // Pixel enable, end-of-line / end-of-frame strobes and raw decode.
    always_comb begin
        active_s = (state_q != ST_IDLE);
        p_tick_s = active_s && (div_q == DIV_LAST);
        eol_s    = p_tick_s && (x_q == X_LAST);
        eof_s    = eol_s && (y_q == Y_LAST);
        x_ext_s  = 32'(x_q);
        y_ext_s  = 32'(y_q);
        raw_s[0] = (x_ext_s < H_VIS) && (y_ext_s < V_VIS);
        raw_s[1] = (x_ext_s >= HS_BEGIN) && (x_ext_s < HS_END);
        raw_s[2] = (y_ext_s >= VS_BEGIN) && (y_ext_s < VS_END);
    end

    // Next-state logic: stop requests are only acted on at end of frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
                else    state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (en)         state_d = ST_RUN;
                else if (eof_s) state_d = ST_IDLE;
                else            state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (en)         state_d = ST_RUN;
                else if (eof_s) state_d = ST_IDLE;
                else            state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
        running_d = (state_d != ST_IDLE);
    end

    // Divider, raster counters and frame counter next values.
    always_comb begin
        div_d   = div_q;
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        if (!active_s) begin
            div_d = '0;
            x_d   = '0;
            y_d   = '0;
        end else if (p_tick_s) begin
            div_d = '0;
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) y_d = '0;
                else               y_d = y_q + CNT_ONE;
            end else begin
                x_d = x_q + CNT_ONE;
            end
        end else begin
            div_d = div_q + DIV_ONE;
        end
        if (eof_s) frame_d = frame_q + FRAME_ONE;
        else       frame_d = frame_q;
    end

    // State and counter registers.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            frame_q   <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            x_q       <= x_d;
            y_q       <= y_d;
            frame_q   <= frame_d;
            running_q <= running_d;
        end
    end

    generate
        if (PIPE == 0) begin : g_no_pipe
            assign dly_s = raw_s;
        end else begin : g_pipe
            logic [2:0] pipe_q [PIPE];
            logic [2:0] pipe_d [PIPE];

            // Delay line advances on p_tick; IDLE flushes it to inactive so a
            // restart never replays stale sync/blank from the previous run.
            always_comb begin
                pipe_d = pipe_q;
                if (!active_s) begin
                    for (int i = 0; i < PIPE; i++) pipe_d[i] = 3'b000;
                end else if (p_tick_s) begin
                    for (int i = PIPE - 1; i > 0; i--) pipe_d[i] = pipe_q[i-1];
                    pipe_d[0] = raw_s;
                end else begin
                    pipe_d = pipe_q;
                end
            end

            // Delay-line registers.
            always_ff @(posedge clk_100MHz or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < PIPE; i++) pipe_q[i] <= 3'b000;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign dly_s = pipe_q[PIPE-1];
        end
    endgenerate

    // Outputs are forced inactive in IDLE, including the edge that enters it.
    assign p_tick       = p_tick_s;
    assign line_tick    = eol_s;
    assign refresh_tick = eof_s;
    assign x            = x_q;
    assign y            = y_q;
    assign frame_cnt    = frame_q;
    assign running      = running_q;
    assign video_on     = active_s && dly_s[0];
    assign hsync        = (active_s && dly_s[1]) ? HS_POL : ~HS_POL;
    assign vsync        = (active_s && dly_s[2]) ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
// Instance a: default 640x480 timing with PIPE=0, line-level directed checks.
// Instance b: tiny raster (8x6 pixels, CLK_DIV=3, PIPE=3) checked every cycle
// against an arithmetic model driven by randomized en toggling.
module tb_vga_timing_gen;

    // Small-raster parameters for instance b.
    localparam int B_CD   = 3;
    localparam int B_HA   = 4;
    localparam int B_HF   = 1;
    localparam int B_HS   = 2;
    localparam int B_HB   = 1;
    localparam int B_VA   = 3;
    localparam int B_VF   = 1;
    localparam int B_VS   = 1;
    localparam int B_VB   = 1;
    localparam int B_PIPE = 3;
    localparam int B_HT   = B_HA + B_HF + B_HS + B_HB;
    localparam int B_VT   = B_VA + B_VF + B_VS + B_VB;
    localparam int B_FL   = B_HT * B_VT;
    localparam bit B_HSP  = 1'b1;
    localparam bit B_VSP  = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic en_a;
    logic en_b;

    logic       a_p_tick, a_video_on, a_hsync, a_vsync, a_line_tick, a_refresh_tick, a_running;
    logic [9:0] a_x, a_y;
    logic [7:0] a_frame_cnt;

    logic       b_p_tick, b_video_on, b_hsync, b_vsync, b_line_tick, b_refresh_tick, b_running;
    logic [3:0] b_x, b_y;
    logic [7:0] b_frame_cnt;

    vga_timing_gen #(.PIPE(0)) u_dut_a (
        .clk_100MHz   (clk),
        .reset        (reset),
        .en           (en_a),
        .p_tick       (a_p_tick),
        .x            (a_x),
        .y            (a_y),
        .video_on     (a_video_on),
        .hsync        (a_hsync),
        .vsync        (a_vsync),
        .line_tick    (a_line_tick),
        .refresh_tick (a_refresh_tick),
        .frame_cnt    (a_frame_cnt),
        .running      (a_running)
    );

    vga_timing_gen #(
        .CLK_DIV (B_CD),
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .HS_POL  (B_HSP), .VS_POL(B_VSP),
        .CW      (4), .PIPE(B_PIPE), .FRAME_W(8)
    ) u_dut_b (
        .clk_100MHz   (clk),
        .reset        (reset),
        .en           (en_b),
        .p_tick       (b_p_tick),
        .x            (b_x),
        .y            (b_y),
        .video_on     (b_video_on),
        .hsync        (b_hsync),
        .vsync        (b_vsync),
        .line_tick    (b_line_tick),
        .refresh_tick (b_refresh_tick),
        .frame_cnt    (b_frame_cnt),
        .running      (b_running)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model for instance b. The raster is a linear pixel index
    // m_pix counted from the start of a run; the generator stops only if en
    // is low on the very last pixel tick of a frame.
    // ------------------------------------------------------------------
    bit m_run;
    int m_cyc;
    int m_pix;
    int m_frames;
    bit chk_b;

    function automatic bit is_tick(input int cyc);
        return (cyc % B_CD) == (B_CD - 1);
    endfunction

    function automatic logic [2:0] decode(input int pos);
        int xx;
        int yy;
        bit vis;
        bit hs;
        bit vs;
        xx  = pos % B_HT;
        yy  = pos / B_HT;
        vis = (xx < B_HA) && (yy < B_VA);
        hs  = (xx >= B_HA + B_HF) && (xx < B_HA + B_HF + B_HS);
        vs  = (yy >= B_VA + B_VF) && (yy < B_VA + B_VF + B_VS);
        return {vs, hs, vis};
    endfunction

    function automatic logic [22:0] b_expect();
        logic [2:0] d;
        int         pos;
        bit         pt;
        bit         lt;
        bit         rt;
        pos = m_pix % B_FL;
        pt  = m_run && is_tick(m_cyc);
        lt  = pt && ((pos % B_HT) == B_HT - 1);
        rt  = lt && ((pos / B_HT) == B_VT - 1);
        if (m_run && (m_pix >= B_PIPE)) d = decode((m_pix - B_PIPE) % B_FL);
        else                            d = 3'b000;
        return {m_run, pt, 4'(pos % B_HT), 4'(pos / B_HT), d[0],
                (d[1] ? B_HSP : ~B_HSP), (d[2] ? B_VSP : ~B_VSP), lt, rt, 8'(m_frames)};
    endfunction

    // Model state advance, mirroring the clock/reset the DUT sees.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run    <= 1'b0;
            m_cyc    <= 0;
            m_pix    <= 0;
            m_frames <= 0;
        end else if (!m_run) begin
            if (en_b) begin
                m_run <= 1'b1;
                m_cyc <= 0;
                m_pix <= 0;
            end
        end else if (is_tick(m_cyc) && ((m_pix % B_FL) == B_FL - 1)) begin
            m_frames <= m_frames + 1;
            if (!en_b) begin
                m_run <= 1'b0;
                m_cyc <= 0;
                m_pix <= 0;
            end else begin
                m_cyc <= m_cyc + 1;
                m_pix <= m_pix + 1;
            end
        end else begin
            m_cyc <= m_cyc + 1;
            if (is_tick(m_cyc)) m_pix <= m_pix + 1;
        end
    end

    // Per-cycle comparison of instance b against the model.
    always @(negedge clk) begin
        if (chk_b)
            check_val("b_cycle",
                      {b_running, b_p_tick, b_x, b_y, b_video_on, b_hsync, b_vsync,
                       b_line_tick, b_refresh_tick, b_frame_cnt},
                      b_expect());
    end

    // Reset-value bundle for instance a (syncs idle high for active-low polarity).
    function automatic logic [34:0] a_obs();
        return {a_running, a_p_tick, a_x, a_y, a_video_on, a_hsync, a_vsync,
                a_line_tick, a_refresh_tick, a_frame_cnt};
    endfunction

    localparam logic [34:0] A_RST = {1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

    initial begin
        int first_pt;
        int pt_cnt;
        int hs_cnt;
        int hs_first;
        int hs_last;
        int vis_cnt;
        int vis_last;
        int lt_cnt;
        int lt_x;
        int waited;
        int stop_at;

        reset = 1'b0;
        en_a  = 1'b1;
        en_b  = 1'b1;
        chk_b = 1'b0;

        // Reset held with en=1: nothing may move.
        repeat (2) @(negedge clk);
        chk_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("a_reset_vals", 64'(a_obs()), 64'(A_RST));
        end

        // Release; scan two full default lines.
        reset    = 1'b1;
        first_pt = -1;
        pt_cnt   = 0;
        hs_cnt   = 0; hs_first = -1; hs_last = -1;
        vis_cnt  = 0; vis_last = -1;
        lt_cnt   = 0; lt_x = -1;
        for (int c = 1; c <= 6400; c++) begin
            @(negedge clk);
            if (c == 1) check_val("a_running_after_e0", 64'(a_running), 64'd1);
            if (a_p_tick) begin
                pt_cnt++;
                if (first_pt < 0) first_pt = c;
                if (a_line_tick) begin
                    lt_cnt++;
                    lt_x = int'(a_x);
                end
                if (a_y == 10'd0) begin
                    if (!a_hsync) begin
                        hs_cnt++;
                        if (hs_first < 0) hs_first = int'(a_x);
                        hs_last = int'(a_x);
                    end
                    if (a_video_on) begin
                        vis_cnt++;
                        vis_last = int'(a_x);
                    end
                end
            end
            if (c == 8) check_val("a_x_after_first_tick", 64'(a_x), 64'd1);
        end
        check_val("a_first_ptick_cycle", 64'(first_pt), 64'd4);
        check_val("a_ptick_count", 64'(pt_cnt), 64'd1600);
        check_val("a_hsync_width", 64'(hs_cnt), 64'd96);
        check_val("a_hsync_first_x", 64'(hs_first), 64'd656);
        check_val("a_hsync_last_x", 64'(hs_last), 64'd751);
        check_val("a_video_count", 64'(vis_cnt), 64'd640);
        check_val("a_video_last_x", 64'(vis_last), 64'd639);
        check_val("a_line_tick_count", 64'(lt_cnt), 64'd2);
        check_val("a_line_tick_x", 64'(lt_x), 64'd799);
        check_val("a_end_pos", 64'({a_y, a_x}), 64'({10'd1, 10'd799}));
        check_val("a_vsync_idle_top", 64'(a_vsync), 64'd1);

        // Keep b running continuously until frame_cnt has wrapped 255 -> 0.
        waited = 0;
        while (m_frames < 258 && waited < 40000) begin
            @(negedge clk);
            waited++;
        end
        check_val("b_wrap_reached", 64'(m_frames >= 258), 64'd1);
        check_val("b_frame_cnt_wrapped", 64'(b_frame_cnt), 64'(8'(m_frames)));

        // Guaranteed full stop, then restart.
        en_b = 1'b0;
        repeat (200) @(negedge clk);
        check_val("b_stopped_idle", 64'({b_running, b_x, b_y}), 64'd0);
        en_b = 1'b1;

        // Randomized en toggling: drops mid-frame, re-raises, frame-end stops.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(39, 0) == 0) en_b = ~en_b;
        end

        // Asynchronous reset mid-frame with en held high.
        en_b = 1'b1;
        waited = 0;
        while (!b_running && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        stop_at = int'($urandom_range(200, 20));
        repeat (stop_at) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_val("a_async_reset", 64'(a_obs()), 64'(A_RST));
        check_val("b_async_reset",
                  {b_running, b_p_tick, b_x, b_y, b_video_on, b_hsync, b_vsync,
                   b_line_tick, b_refresh_tick, b_frame_cnt},
                  {1'b0, 1'b0, 4'd0, 4'd0, 1'b0, ~B_HSP, ~B_VSP, 1'b0, 1'b0, 8'd0});
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (600) @(negedge clk);

        chk_b = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: next generation of the fixed 640x480 controller. It derives a pixel-clock enable from the system clock and runs horizontal/vertical counters. It decodes sync and blanking with programmable porches and polarities, and delays sync/blank by a configurable number of pixel ticks to match downstream pixel-pipeline latency. Frame-boundary start/stop control, line/frame ticks and a frame counter feed the renderer and frame-buffer logic.

## Interface
- CLK_DIV, 4, system clocks per pixel (>=1; 4 gives 25 MHz from 100 MHz)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CW, 10, width of x/y (must hold H_TOTAL-1 and V_TOTAL-1)
- PIPE, 2, pixel-tick delay of hsync/vsync/video_on relative to x/y (>=0)
- FRAME_W, 8, frame counter width

Ports:
- clk_100MHz  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  run request; start/stop honoured only at frame boundary
- p_tick  out  1  pixel enable, one clk wide
- x  out  CW  horizontal counter
- y  out  CW  vertical counter
- video_on  out  1  visible-area flag, delayed PIPE pixel ticks
- hsync  out  1  delayed PIPE pixel ticks, polarity HS_POL
- vsync  out  1  delayed PIPE pixel ticks, polarity VS_POL
- line_tick  out  1  one-clk pulse on last pixel of each line
- refresh_tick  out  1  one-clk pulse on last pixel of each frame
- frame_cnt  out  FRAME_W  completed frames, wraps modulo 2^FRAME_W
- running  out  1  high when state is RUN or DRAIN

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- FSM states:
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN -> RUN when en=1 (no visible interruption).
  - DRAIN -> IDLE on the p_tick where x=H_TOTAL-1 and y=V_TOTAL-1.
  - RUN with en=0 on that same end-of-frame p_tick goes directly to IDLE.
- IDLE: divider held at 0, x=y=0, p_tick=0, video_on=0, hsync=~HS_POL, vsync=~VS_POL, pipeline registers flushed to these inactive values.
- Divider: counts 0..CLK_DIV-1 when not IDLE. p_tick = (state!=IDLE) && div==CLK_DIV-1, combinational. With CLK_DIV=1, p_tick is high every non-IDLE cycle.
- On p_tick, x increments and wraps H_TOTAL-1 -> 0. On that wrap, y increments and wraps V_TOTAL-1 -> 0.
- Raw decode from current x/y:
  - visible = x<H_ACTIVE && y<V_ACTIVE.
  - hs_act when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vs_act when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
  - Output levels: hsync = hs_act ? HS_POL : ~HS_POL; vsync likewise with VS_POL.
- Delay line: PIPE register stages, shifted only on p_tick. PIPE=0 means outputs are the combinational raw decode.
- line_tick = p_tick && x==H_TOTAL-1.
- refresh_tick = line_tick && y==V_TOTAL-1. frame_cnt increments on the same edge.

## Timing
- Reset (reset=0, asynchronous): state IDLE, div=0, x=y=0, frame_cnt=0, all ticks 0, video_on=0, syncs inactive, running=0.
- en sampled high in IDLE at edge E0: running=1 after E0. First p_tick is high during the cycle after edge E(CLK_DIV-1). x becomes 1 at edge E(CLK_DIV).
- p_tick period is exactly CLK_DIV clocks while running.
- x/y change on the edge that ends a p_tick cycle. Sync/blank outputs reflect the x/y value from PIPE pixel ticks earlier.
- Frame period (defaults): 800*525*4 = 1,680,000 clocks between refresh_tick pulses.
- Stop: the frame in progress always completes. After the final wrap, x=y=0 and outputs go inactive on the same edge the state enters IDLE. Delay-line contents are discarded.
- Reset asserted mid-frame: immediate return to reset values, regardless of state or en.

## Test plan
- Reset values: hold reset=0 with en=1 -> all outputs at reset values, p_tick never high, running=0.
- Line timing (defaults, PIPE=0): en=1 -> hsync low for exactly 96 p_ticks, starting at x=656. video_on high for x 0..639 on y<480. line_tick fires at x=799.
- Frame timing: vsync low for lines 490-491. refresh_tick spacing 1,680,000 clocks. frame_cnt wraps 255 -> 0 after 256 frames (use small H/V parameters for speed).
- Stop/restart: drop en at y=100 -> frame continues to x=799, y=524, then IDLE with x=y=0. Drop and re-raise en within the same frame -> no gap in p_tick, frame_cnt unaffected.
- Pipeline: PIPE=3, H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 -> hsync asserted at x=8 (5+3), deasserted at x=10 mod 8 wrap, i.e. x=2 of the next line.
- Async reset mid-frame at x=300, y=200 -> outputs at reset values within the same cycle. With en still 1, restart from x=y=0 after release.
